// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment codes, digit type and monitor
// state encoding. Also used by the display driver.
package seg7_pkg;

  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hE6;
  localparam logic [7:0] SEG_ALL_ON = 8'hFF;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    NO_REF = 1'b0,
    TRACK  = 1'b1
  } state_t;

  function automatic digit_t next_digit(input digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD digit decoder.
// Any pattern outside the ten digit codes (dp set included) is not legal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pat,
  output digit_t     digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    unique case (pat)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Segment-bus monitor: debounces the pattern, decodes it and checks
// that accepted digits follow the mod-10 up-count sequence.
module seg7_decode_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [7:0]           led,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 invalid,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [7:0]           led_q, led_d;
  logic [7:0]           stab_cnt_q, stab_cnt_d;
  logic [7:0]           last_pat_q, last_pat_d;
  state_t               state_q, state_d;
  digit_t               digit_q, digit_d;
  logic                 digit_valid_q, digit_valid_d;
  logic                 invalid_q, invalid_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  digit_t dec_digit;
  logic   dec_legal;
  logic   accept;

  seg7_pattern_decode u_decode (
    .pat   (led_q),
    .digit (dec_digit),
    .legal (dec_legal)
  );

  always_comb begin
    led_d         = led;
    stab_cnt_d    = stab_cnt_q;
    last_pat_d    = last_pat_q;
    state_d       = state_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    invalid_d     = 1'b0;
    seq_err_d     = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (led != led_q) begin
      stab_cnt_d = 8'd1;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end

    // last_pat gates acceptance to once per stable pattern
    accept = (stab_cnt_q == STAB_MAX) && (led_q != last_pat_q);

    if (accept) begin
      last_pat_d = led_q;
      if (dec_legal) begin
        digit_valid_d = 1'b1;
        digit_d       = dec_digit;
        state_d       = TRACK;
        if (state_q == TRACK &&
            dec_digit != next_digit(digit_q) &&
            dec_digit != 4'd0) begin
          seq_err_d = 1'b1;
        end
      end else begin
        invalid_d = 1'b1;
        state_d   = NO_REF;
      end
    end

    if ((invalid_d || seq_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      led_q         <= 8'h00;
      stab_cnt_q    <= 8'd0;
      last_pat_q    <= 8'h00;
      state_q       <= NO_REF;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      invalid_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      led_q         <= led_d;
      stab_cnt_q    <= stab_cnt_d;
      last_pat_q    <= last_pat_d;
      state_q       <= state_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      invalid_q     <= invalid_d;
      seq_err_q     <= seq_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign invalid     = invalid_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Bench for seg7_decode_monitor: directed test-plan steps plus random
// hold sequences, all checked against a run-length reference model.
module tb_seg7_decode_monitor;

  localparam int S = 4;
  localparam int W = 8;
  localparam int ERR_MAX = 255;

  logic         clock = 1'b0;
  logic         rst;
  logic [7:0]   led;
  logic [3:0]   digit;
  logic         digit_valid;
  logic         invalid;
  logic         seq_err;
  logic [W-1:0] err_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] lut [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                           8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

  // reference model state
  logic [7:0] m_ledq;
  logic [7:0] m_last;
  int         m_run;
  bit         m_have_ref;
  int         m_digit;
  int         m_err;
  bit         e_dv, e_inv, e_se;

  int dv_seen, inv_seen, se_seen;

  always #5 clock = ~clock;

  seg7_decode_monitor #(
    .STABLE_CYCLES (S),
    .ERR_CNT_W     (W)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .led         (led),
    .digit       (digit),
    .digit_valid (digit_valid),
    .invalid     (invalid),
    .seq_err     (seq_err),
    .err_count   (err_count)
  );

  function automatic int seg_to_digit(input logic [7:0] p);
    for (int i = 0; i < 10; i++)
      if (lut[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ledq = 8'h00;
    m_last = 8'h00;
    m_run = 0;
    m_have_ref = 0;
    m_digit = 0;
    m_err = 0;
    e_dv = 0;
    e_inv = 0;
    e_se = 0;
  endtask

  task automatic clr_seen();
    dv_seen = 0;
    inv_seen = 0;
    se_seen = 0;
  endtask

  // one clock of stimulus, model update and output comparison
  task automatic step(input logic [7:0] p);
    int d;
    @(negedge clock);
    led = p;
    @(posedge clock);
    e_dv = 0;
    e_inv = 0;
    e_se = 0;
    if (m_run == S && m_ledq != m_last) begin
      m_last = m_ledq;
      d = seg_to_digit(m_ledq);
      if (d >= 0) begin
        e_dv = 1;
        if (m_have_ref && d != (m_digit + 1) % 10 && d != 0) e_se = 1;
        m_digit = d;
        m_have_ref = 1;
      end else begin
        e_inv = 1;
        m_have_ref = 0;
      end
      if ((e_inv || e_se) && m_err < ERR_MAX) m_err++;
    end
    if (p == m_ledq) m_run = (m_run < S) ? m_run + 1 : S;
    else m_run = 1;
    m_ledq = p;
    #1;
    chk("digit", 32'(digit), 32'(m_digit));
    chk("digit_valid", 32'(digit_valid), 32'(e_dv));
    chk("invalid", 32'(invalid), 32'(e_inv));
    chk("seq_err", 32'(seq_err), 32'(e_se));
    chk("err_count", 32'(err_count), 32'(m_err));
    if (digit_valid === 1'b1) dv_seen++;
    if (invalid === 1'b1) inv_seen++;
    if (seq_err === 1'b1) se_seen++;
  endtask

  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  initial begin
    logic [7:0] p;
    int n;
    rst = 1'b1;
    led = 8'h00;
    model_reset();
    clr_seen();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_digit", 32'(digit), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_pulses", {29'd0, digit_valid, invalid, seq_err}, 0);
    @(negedge clock);
    rst = 1'b0;

    // first digit: pulse on the fifth edge
    hold(8'hFC, 4);
    chk("first_no_pulse_yet", 32'(dv_seen), 0);
    step(8'hFC);
    chk("first_dv", 32'(digit_valid), 1);
    chk("first_digit", 32'(digit), 0);
    chk("first_seq_err", 32'(seq_err), 0);

    // full count sequence 1..9 then wrap to 0
    clr_seen();
    for (int i = 1; i <= 10; i++) hold(lut[i % 10], 6);
    chk("seq_dv_count", 32'(dv_seen), 10);
    chk("seq_err_count", 32'(se_seen), 0);

    // glitch rejection
    hold(8'h60, 6);
    clr_seen();
    hold(8'hDA, 3);
    hold(8'h60, 8);
    chk("glitch_events", 32'(dv_seen + inv_seen + se_seen), 0);

    // sequence error 3 -> 6
    hold(8'hDA, 6);
    hold(8'hF2, 6);
    hold(8'hBE, 5);
    chk("se_dv", 32'(digit_valid), 1);
    chk("se_pulse", 32'(seq_err), 1);
    chk("se_digit", 32'(digit), 6);
    chk("se_err_count", 32'(err_count), 1);

    // illegal pattern then re-sync without sequence check
    clr_seen();
    hold(8'hFF, 10);
    chk("illegal_once", 32'(inv_seen), 1);
    hold(8'h66, 6);
    chk("resync_dv", 32'(dv_seen), 1);
    chk("resync_digit", 32'(digit), 4);
    chk("resync_no_se", 32'(se_seen), 0);

    // random holds, biased towards the legal successor
    for (int k = 0; k < 80; k++) begin
      n = $urandom_range(1, 7);
      case ($urandom_range(0, 9))
        0, 1:    p = 8'($urandom);
        2, 3, 4: p = lut[$urandom_range(0, 9)];
        default: p = lut[(m_digit + 1) % 10];
      endcase
      hold(p, n);
    end

    // saturation with alternating illegal patterns
    for (int k = 0; k < 300; k++) hold((k % 2) ? 8'h01 : 8'hFF, S);
    step(8'hFF);
    chk("sat_err_count", 32'(err_count), ERR_MAX);

    // async reset mid-pattern
    hold(8'hFC, 2);
    @(posedge clock);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_digit", 32'(digit), 0);
    chk("arst_err", 32'(err_count), 0);
    chk("arst_pulses", {29'd0, digit_valid, invalid, seq_err}, 0);
    model_reset();
    @(negedge clock);
    rst = 1'b0;
    clr_seen();
    hold(8'hB6, S + 1);
    chk("post_rst_dv", 32'(dv_seen), 1);
    chk("post_rst_no_se", 32'(se_seen), 0);
    chk("post_rst_digit", 32'(digit), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_decode_monitor.md
# seg7_decode_monitor

Receive-side companion to the team's BCD-to-7-segment LED driver. The block samples the 8-bit segment bus and waits for each pattern to be stable for a programmable number of cycles. It then decodes the pattern back to a BCD digit and checks that successive digits follow the mod-10 up-count sequence. It sits beside the display driver, or in a loopback test path, as a self-check and error counter.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 1..255)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clock  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- led  in  8  segment pattern; bit7=a … bit1=g, bit0=dp; 1 = segment lit
- digit  out  4  last accepted BCD digit
- digit_valid  out  1  one-cycle pulse when a new valid digit is accepted
- invalid  out  1  one-cycle pulse when a new stable pattern is not a legal digit
- seq_err  out  1  one-cycle pulse when an accepted digit breaks the count sequence
- err_count  out  ERR_CNT_W  saturating count of invalid and seq_err events

## Operation
- **Input sampling:** led is registered once into led_q on every clock edge.
- **Stability counter:**
  - stab_cnt resets to 1 whenever led_q differs from its previous value.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- **Acceptance:** occurs in the cycle where stab_cnt reaches STABLE_CYCLES and led_q differs from last_pat.
  - last_pat is then updated to led_q.
  - At most one acceptance occurs per stable pattern.
- **Decode table:**
  - 0xFC→0, 0x60→1, 0xDA→2, 0xF2→3, 0x66→4, 0xB6→5, 0xBE→6, 0xE0→7, 0xFE→8, 0xE6→9.
  - Every other value is illegal, including 0xFF and any pattern with dp set.
- **State machine:**
  - NO_REF (reset state): no reference digit is held.
    - Valid acceptance: digit updated, digit_valid pulses, go to TRACK, no sequence check.
    - Invalid acceptance: invalid pulses, stay in NO_REF.
  - TRACK: a reference digit is held.
    - Valid acceptance of d: digit_valid pulses and digit←d.
    - If d ≠ (digit+1) mod 10 and d ≠ 0, seq_err also pulses in the same cycle.
    - 9→0 wrap is legal. Any →0 is legal, because the encoder was reset.
    - Invalid acceptance: invalid pulses, digit is unchanged, go to NO_REF.
- **err_count:** increments by 1 on invalid or on seq_err; the two never occur in the same cycle. It holds at all-ones once reached.
- **Glitch rejection:** a pattern held for fewer than STABLE_CYCLES samples is never accepted and never flagged. A return to last_pat after a glitch produces no event.

## Timing
- **Reset values:** digit=0, digit_valid=0, invalid=0, seq_err=0, err_count=0, state=NO_REF.
  - led_q resets to 0x00 and last_pat resets to 0x00, which is illegal and never matches a digit.
  - stab_cnt resets to 0.
- **Latency:** led changes before edge E0 and is held.
  - led_q shows the new value after E0.
  - The acceptance condition is met after edge E0+STABLE_CYCLES−1.
  - The pulse outputs are registered at E0+STABLE_CYCLES.
  - Total latency is STABLE_CYCLES+1 edges from the first sampling edge.
- **Pulse width:** all pulse outputs are exactly one cycle wide and fully registered; there are no combinational paths from led.
- **Reset mid-count:** asserting rst discards any partial stability count immediately. After release, the first stable pattern is handled in NO_REF.

## Structure
- **Package seg7_pkg:**
  - Segment constants SEG_0..SEG_9.
  - SEG_ALL_ON = 8'hFF.
  - Digit typedef logic [3:0].
  - State enum {NO_REF, TRACK}.
  - Also shared with the display driver.
- **Sub-module seg7_pattern_decode:** purely combinational; input pattern, outputs digit and legal flag. It is reused by any future multi-digit scanner.
- **Top level:** sampling register, stability counter, FSM and error counter.

## Test plan
- **Reset:** reset, then drive 0xFC held 4 cycles (STABLE_CYCLES=4) → digit=0 and digit_valid pulses on edge 5; no seq_err; err_count=0.
- **Full count sequence:** 0→1→…→9→0, each held 6 cycles → ten digit_valid pulses with matching digit; seq_err never asserts.
- **Glitch rejection:** hold 0x60, insert 0xDA for 3 cycles, return to 0x60 → no event during or after the glitch.
- **Sequence error:** from digit 3, drive 0xBE (6) held 4 cycles → digit_valid and seq_err pulse together; digit=6; err_count=1.
- **Illegal pattern:** drive 0xFF held 10 cycles → exactly one invalid pulse; state NO_REF; next 0x66 gives digit_valid=4 with no seq_err.
- **Saturation and async reset:** force 300 alternating illegal patterns → err_count saturates at 255; asserting rst mid-pattern clears all outputs without waiting for a clock edge.
